// File: rtl/icache_fill_responder.sv
// Memory-side responder for icache fill requests: latches a miss address, runs one
// RAM word read, and answers with a single-cycle iwait release or a timeout/error word.
module icache_fill_responder #(
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    output logic        ierr,
    output logic        ramREN,
    output logic [31:0] ramaddr,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam int              CW        = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [1:0]      RAM_ACCESS = 2'd2;
    localparam logic [1:0]      RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          err_q, err_d;
    logic [31:0]   reqAddr;

    // Masking keeps every iaddr bit in use while forcing a word-aligned address.
    assign reqAddr = iaddr & ~32'h3;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        iwait   = iREN;
        iload   = '0;
        ierr    = 1'b0;
        ramREN  = 1'b0;
        ramaddr = '0;

        case (state_q)
            IDLE: begin
                if (iREN) begin
                    state_d = ACCESS;
                    addr_d  = reqAddr;
                    cnt_d   = '0;
                end
            end
            ACCESS: begin
                ramREN  = 1'b1;
                ramaddr = addr_q;
                iwait   = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                // Withdrawal beats a retarget, and a retarget beats any completion.
                if (!iREN) begin
                    state_d = IDLE;
                end else if (reqAddr != addr_q) begin
                    addr_d = reqAddr;
                    cnt_d  = '0;
                end else if (ramstate == RAM_ACCESS) begin
                    state_d = DONE;
                    data_d  = ramload;
                    err_d   = 1'b0;
                end else if ((ramstate == RAM_ERROR) || (cnt_q == CNT_LAST)) begin
                    state_d = DONE;
                    data_d  = ERR_WORD;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                iwait   = 1'b0;
                iload   = data_q;
                ierr    = err_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_icache_fill_responder.sv
// Randomized and directed bench for icache_fill_responder, checked against a
// request/response reference model kept in the bench.
module tb_icache_fill_responder;

   localparam int          TIMEOUT  = 64;
   localparam logic [31:0] ERR_WORD = 32'hBAD1BAD1;
   localparam logic [1:0]  RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;

   logic        CLK = 1'b0;
   logic        RST;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        ierr;
   logic        ramREN;
   logic [31:0] ramaddr;
   logic [31:0] ramload;
   logic [1:0]  ramstate;

   int checks = 0;
   int failures = 0;

   // Reference model: is a request outstanding, is a response due this cycle,
   // which word is wanted, and how many cycles the RAM has been waited on.
   bit          mInFlight;
   bit          mRespond;
   logic [29:0] mWord;
   int          mWaited;
   logic [31:0] mRespWord;
   bit          mRespErr;

   icache_fill_responder #(.TIMEOUT(TIMEOUT), .ERR_WORD(ERR_WORD)) dut (
      .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr),
      .iwait(iwait), .iload(iload), .ierr(ierr),
      .ramREN(ramREN), .ramaddr(ramaddr),
      .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   // Single comparison point: counts every check and reports any disagreement.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advances the model by one clock using the inputs that were sampled at that edge.
   task automatic modelEdge();
      if (RST) begin
         mInFlight = 0; mRespond = 0; mWord = '0; mWaited = 0; mRespWord = '0; mRespErr = 0;
      end else if (mRespond) begin
         mRespond = 0;
      end else if (!mInFlight) begin
         if (iREN) begin
            mInFlight = 1; mWord = iaddr[31:2]; mWaited = 0;
         end
      end else if (!iREN) begin
         mInFlight = 0;
      end else if (iaddr[31:2] != mWord) begin
         mWord = iaddr[31:2]; mWaited = 0;
      end else if (ramstate == RS_ACCESS) begin
         mInFlight = 0; mRespond = 1; mRespWord = ramload; mRespErr = 0;
      end else if (ramstate == RS_ERROR || mWaited + 1 == TIMEOUT) begin
         mInFlight = 0; mRespond = 1; mRespWord = ERR_WORD; mRespErr = 1;
      end else begin
         mWaited++;
      end
   endtask

   // Compares all outputs with what the model predicts for the current inputs.
   task automatic compareAll();
      logic expWait;
      expWait = mRespond ? 1'b0 : (mInFlight ? 1'b1 : iREN);
      checkOutput("iwait", 32'(iwait), 32'(expWait));
      checkOutput("ramREN", 32'(ramREN), 32'(mInFlight));
      checkOutput("iload", iload, mRespond ? mRespWord : 32'h0);
      checkOutput("ierr", 32'(ierr), 32'(mRespond & mRespErr));
      if (mInFlight) checkOutput("ramaddr", ramaddr, {mWord, 2'b00});
   endtask

   // Drives one cycle of inputs, checks outputs before the edge, then clocks model and DUT.
   task automatic applyStimulus(input logic rst, input logic ren, input logic [31:0] addr,
                                input logic [1:0] rs, input logic [31:0] rl);
      RST = rst; iREN = ren; iaddr = addr; ramstate = rs; ramload = rl;
      #1;
      compareAll();
      @(posedge CLK);
      modelEdge();
      #1;
   endtask

   initial begin
      logic [31:0] curAddr;
      logic        curRen;
      int          r;

      RST = 1'b1; iREN = 1'b0; iaddr = '0; ramstate = RS_FREE; ramload = '0;
      repeat (3) @(posedge CLK);
      modelEdge();
      #1;
      RST = 1'b0;
      #1;
      checkOutput("rst_iwait", 32'(iwait), 32'h0);
      checkOutput("rst_iload", iload, 32'h0);
      checkOutput("rst_ierr", 32'(ierr), 32'h0);
      checkOutput("rst_ramREN", 32'(ramREN), 32'h0);
      checkOutput("rst_ramaddr", ramaddr, 32'h0);

      applyStimulus(0, 1, 32'h0000_0047, RS_FREE, 32'h0);
      checkOutput("t2_ramaddr", ramaddr, 32'h0000_0044);
      applyStimulus(0, 1, 32'h0000_0047, RS_BUSY, 32'h0);
      applyStimulus(0, 1, 32'h0000_0047, RS_BUSY, 32'h0);
      applyStimulus(0, 1, 32'h0000_0047, RS_ACCESS, 32'hDEADBEEF);
      checkOutput("t2_iwait", 32'(iwait), 32'h0);
      checkOutput("t2_iload", iload, 32'hDEADBEEF);
      checkOutput("t2_ierr", 32'(ierr), 32'h0);
      applyStimulus(0, 0, 32'h0, RS_FREE, 32'h0);

      applyStimulus(0, 1, 32'h0000_0100, RS_FREE, 32'h0);
      for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(0, 1, 32'h0000_0100, RS_BUSY, 32'h0);
      checkOutput("t3_still_wait", 32'(iwait), 32'h1);
      applyStimulus(0, 1, 32'h0000_0100, RS_BUSY, 32'h0);
      checkOutput("t3_iload", iload, 32'hBAD1BAD1);
      checkOutput("t3_ierr", 32'(ierr), 32'h1);
      applyStimulus(0, 0, 32'h0, RS_FREE, 32'h0);

      applyStimulus(0, 1, 32'h0000_0040, RS_FREE, 32'h0);
      applyStimulus(0, 1, 32'h0000_0080, RS_ACCESS, 32'h1111_1111);
      checkOutput("t4_no_done", 32'(iwait), 32'h1);
      checkOutput("t4_ramaddr", ramaddr, 32'h0000_0080);
      for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(0, 1, 32'h0000_0080, RS_BUSY, 32'h0);
      checkOutput("t4_cnt_restart", 32'(iwait), 32'h1);
      applyStimulus(0, 1, 32'h0000_0080, RS_BUSY, 32'h0);
      checkOutput("t4_timeout_err", 32'(ierr), 32'h1);
      applyStimulus(0, 0, 32'h0, RS_FREE, 32'h0);

      applyStimulus(0, 1, 32'h0000_0200, RS_BUSY, 32'h0);
      applyStimulus(0, 1, 32'h0000_0200, RS_BUSY, 32'h0);
      applyStimulus(0, 0, 32'h0000_0200, RS_ACCESS, 32'h2222_2222);
      checkOutput("t5_ramREN", 32'(ramREN), 32'h0);
      checkOutput("t5_iload", iload, 32'h0);

      applyStimulus(0, 1, 32'h0000_0300, RS_FREE, 32'h0);
      applyStimulus(0, 1, 32'h0000_0300, RS_ACCESS, 32'h3333_3333);
      checkOutput("t6_done", iload, 32'h3333_3333);
      applyStimulus(0, 1, 32'h0000_0304, RS_FREE, 32'h0);
      checkOutput("t6_idle_ramREN", 32'(ramREN), 32'h0);
      applyStimulus(0, 1, 32'h0000_0304, RS_BUSY, 32'h0);
      checkOutput("t6_second_access", 32'(ramREN), 32'h1);
      checkOutput("t6_second_addr", ramaddr, 32'h0000_0304);
      applyStimulus(1, 0, 32'h0000_0304, RS_ACCESS, 32'h4444_4444);
      checkOutput("t6_rst_ramREN", 32'(ramREN), 32'h0);
      checkOutput("t6_rst_iwait", 32'(iwait), 32'h0);

      // Random traffic: mostly held requests, occasional retargets, withdrawals and resets.
      curAddr = $urandom;
      curRen  = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 99);
         if (curRen) curRen = (r >= 4);
         else        curRen = (r < 50);
         if ($urandom_range(0, 15) == 0) curAddr = $urandom;
         r = $urandom_range(0, 9);
         applyStimulus($urandom_range(0, 199) == 0, curRen, curAddr,
                       (r < 6) ? RS_BUSY : (r < 8) ? RS_ACCESS : (r < 9) ? RS_ERROR : RS_FREE,
                       $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
